vga_line_fetch: RTL and testbench



---
 rtl/vga_line_fetch.sv | 131 +++++++++++++
 tb/tb_vga_line_fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: scanline prefetch controller feeding the VGA timing generator.
//   Fetches framebuffer rows one line ahead into a two-bank line buffer and
//   serves each stored word for two advance cycles (2x horizontal doubling).
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   base              framebuffer base word address, sampled when a fetch starts
//   newline, line     scanline start pulse and the row to display on it
//   advance           active-pixel strobe; pixel is valid in the same cycle
//   pixel             pixel word for the current advance cycle (black otherwise)
//   rd_req/rd_addr    memory read request and registered address
//   rd_ack/rd_data    request accepted, read data valid in the same cycle
//   underflow         sticky: a scanline started with no matching bank
//   busy              fetch (or abort drain) in progress
module vga_line_fetch #(
   parameter int BPP   = 4,
   parameter int WIDTH = 320,
   parameter int LINES = 240,
   parameter int AW    = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     base,
   input  logic              newline,
   input  logic [7:0]        line,
   input  logic              advance,
   output logic [3*BPP-1:0]  pixel,
   output logic              rd_req,
   output logic [AW-1:0]     rd_addr,
   input  logic              rd_ack,
   input  logic [3*BPP-1:0]  rd_data,
   output logic              underflow,
   output logic              busy
);
   localparam int PW = 3 * BPP;
   localparam int NW = $clog2(WIDTH);
   localparam int KW = $clog2(2 * WIDTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   bank_mem [2][WIDTH];
   logic [7:0]      tag_row [2];
   logic [1:0]      tag_vld;
   logic            disp_bank, blank, f_bank;
   logic [7:0]      f_row, t, load_row;
   logic [NW-1:0]   n;
   logic [KW-1:0]   k;
   logic            hit0, hit1, thit, in_prog, start, new_disp, last, load, ack_wr;

   // Row offset T*WIDTH built as a shift-add sum of WIDTH, no multiplier.
   function automatic logic [AW-1:0] row_off(input logic [7:0] r);
      logic [AW-1:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++)
         if (r[i]) acc = acc + AW'(WIDTH << i);
      return acc;
   endfunction

   assign hit0     = tag_vld[0] && tag_row[0] == line;
   assign hit1     = tag_vld[1] && tag_row[1] == line;
   assign new_disp = hit0 ? 1'b0 : hit1 ? 1'b1 : disp_bank;
   assign t        = (line == 8'(LINES - 1)) ? 8'd0 : line + 8'd1;
   assign thit     = (tag_vld[0] && tag_row[0] == t) || (tag_vld[1] && tag_row[1] == t);
   // In DRAIN, f_row already names the pending row, so it counts as in progress.
   assign in_prog  = state != IDLE && f_row == t;
   assign start    = newline && !thit && !in_prog;
   assign last     = n == NW'(WIDTH - 1);
   assign ack_wr   = state == REQ && rd_ack && !start;
   // A new address is loaded once nothing is left outstanding: straight from
   // IDLE, on an abort whose request is acked that same cycle, or out of DRAIN.
   assign load     = start ? (state != REQ || rd_ack) : (state == DRAIN && rd_ack);
   assign load_row = start ? t : f_row;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_comb begin
      state_n = state;
      rd_req  = state != IDLE;
      busy    = state != IDLE;
      pixel   = (advance && !blank && k < KW'(2 * WIDTH)) ? bank_mem[disp_bank][k[KW-1:1]] : '0;
      if (load)               state_n = REQ;
      else if (start)         state_n = DRAIN;
      else if (ack_wr && last) state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_addr    <= '0;
         n          <= '0;
         f_row      <= '0;
         f_bank     <= 1'b0;
         tag_vld    <= '0;
         tag_row[0] <= '0;
         tag_row[1] <= '0;
         disp_bank  <= 1'b0;
         blank      <= 1'b1;
         k          <= '0;
         underflow  <= 1'b0;
      end else begin
         if (newline) begin
            disp_bank <= new_disp;
            blank     <= !(hit0 || hit1);
            underflow <= underflow || !(hit0 || hit1);
            k         <= '0;
         end else if (advance && k < KW'(2 * WIDTH))
            k <= k + 1'b1;
         if (start) begin
            f_row              <= t;
            f_bank             <= ~new_disp;
            tag_vld[~new_disp] <= 1'b0;
         end
         if (load) begin
            rd_addr <= base + row_off(load_row);
            n       <= '0;
         end else if (ack_wr) begin
            if (last) begin
               tag_vld[f_bank] <= 1'b1;
               tag_row[f_bank] <= f_row;
            end else begin
               n       <= n + 1'b1;
               rd_addr <= rd_addr + 1'b1;
            end
         end
      end

   // Line buffer: written only by accepted, non-aborted fetch data.
   always_ff @(posedge clk)
      if (ack_wr) bank_mem[f_bank][n] <= rd_data;
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed bench for vga_line_fetch (table of scanlines plus
//   hand-written mid-fetch, abort and reset sequences).
module tb_vga_line_fetch;
   localparam int W = 320;
   localparam logic [16:0] BASE = 17'h00400;

   logic        clk = 0, rst = 0, newline = 0, advance = 0, rd_ack = 0;
   logic [7:0]  line = 0;
   logic [16:0] base = BASE;
   logic [11:0] pixel, rd_data;
   logic        rd_req, underflow, busy;
   logic [16:0] rd_addr;
   logic [16:0] acc_q[$];
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic [7:0] ln;
      bit         hit;
      int         row;
      int         nreq;
      bit         uf;
   } vec_t;
   vec_t vecs[8];

   vga_line_fetch dut (
      .clk(clk), .rst(rst), .base(base), .newline(newline), .line(line),
      .advance(advance), .pixel(pixel), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_data(rd_data), .underflow(underflow), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] dat(input logic [16:0] a);
      return 12'(a * 13 + 5);
   endfunction

   assign rd_data = dat(rd_addr);

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, sample 1 ns later.
   task automatic step(input bit nl, input logic [7:0] ln, input bit adv, input bit ack);
      @(negedge clk);
      newline = nl;
      line    = ln;
      advance = adv;
      rd_ack  = ack;
      #1;
      if (rd_req && rd_ack) acc_q.push_back(rd_addr);
   endtask

   function automatic int addr_errs(input int row);
      int e = 0;
      foreach (acc_q[i])
         if (int'(acc_q[i]) != int'(BASE) + row * W + i) e++;
      return e;
   endfunction

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 700 && busy; i++) step(0, 0, 0, 1);
      chk({nm, "_busy_drop"}, int'(busy), 0);
   endtask

   task automatic run_line(input vec_t v);
      int bad = 0;
      bit first_req = 0;
      logic [11:0] exp;
      acc_q.delete();
      step(1, v.ln, 0, 1);
      for (int k = 0; k < 2 * W + 4; k++) begin
         step(0, 0, 1, 1);
         if (k == 0) first_req = rd_req;
         exp = (v.hit && k < 2 * W) ? dat(17'(int'(BASE) + int'(v.ln) * W + k / 2)) : 12'd0;
         if (pixel !== exp) bad++;
      end
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 1);
         if (pixel !== 12'd0) bad++;
      end
      chk($sformatf("pix_bad_l%0d", v.ln), bad, 0);
      chk($sformatf("first_req_l%0d", v.ln), int'(first_req), int'(v.nreq > 0));
      chk($sformatf("nreq_l%0d", v.ln), acc_q.size(), v.nreq);
      chk($sformatf("addr_err_l%0d", v.ln), addr_errs(v.row), 0);
      chk($sformatf("busy_l%0d", v.ln), int'(busy), 0);
      chk($sformatf("underflow_l%0d", v.ln), int'(underflow), int'(v.uf));
   endtask

   initial begin
      int held;
      vecs[0] = '{8'd0,   1'b0, 1, 320, 1'b1};
      vecs[1] = '{8'd1,   1'b1, 2, 320, 1'b1};
      vecs[2] = '{8'd2,   1'b1, 3, 320, 1'b1};
      vecs[3] = '{8'd2,   1'b1, 0, 0,   1'b1};
      vecs[4] = '{8'd3,   1'b1, 4, 320, 1'b1};
      vecs[5] = '{8'd239, 1'b0, 0, 320, 1'b1};
      vecs[6] = '{8'd0,   1'b1, 1, 320, 1'b1};
      vecs[7] = '{8'd1,   1'b1, 2, 320, 1'b1};

      #1 rst = 1;
      advance = 1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_req", int'(rd_req), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_pixel", int'(pixel), 0);
      chk("rst_underflow", int'(underflow), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 0;
      advance = 0;

      foreach (vecs[i]) run_line(vecs[i]);

      // Repeated newline for row 5 must not restart the row-6 fetch.
      acc_q.delete();
      step(1, 5, 0, 1);
      repeat (100) step(0, 0, 0, 1);
      step(1, 5, 0, 1);
      wait_idle("s1");
      chk("s1_nreq", acc_q.size(), 320);
      chk("s1_addr_err", addr_errs(6), 0);

      // Abort: row-10 fetch stalled, newline for row 20 drains then fetches row 21.
      acc_q.delete();
      step(1, 9, 0, 1);
      repeat (50) step(0, 0, 0, 1);
      chk("s2_acked", acc_q.size(), 50);
      held = 0;
      repeat (3) begin
         step(0, 0, 0, 0);
         if (!(rd_req && int'(rd_addr) == int'(BASE) + 10 * W + 50)) held++;
      end
      chk("s2_hold", held, 0);
      step(1, 20, 0, 0);
      step(0, 0, 0, 0);
      chk("s2_drain_req", int'(rd_req), 1);
      chk("s2_drain_addr", int'(rd_addr), int'(BASE) + 10 * W + 50);
      chk("s2_drain_busy", int'(busy), 1);
      step(0, 0, 0, 1);
      acc_q.delete();
      step(0, 0, 0, 1);
      chk("s2_new_req", int'(rd_req), 1);
      chk("s2_new_addr", int'(rd_addr), int'(BASE) + 21 * W);
      wait_idle("s2");
      chk("s2_nreq", acc_q.size(), 320);
      chk("s2_addr_err", addr_errs(21), 0);
      run_line('{8'd21, 1'b1, 22, 320, 1'b1});

      // Asynchronous reset in the middle of a fetch.
      acc_q.delete();
      step(1, 30, 0, 1);
      repeat (40) step(0, 0, 0, 1);
      chk("s3_pre_req", int'(rd_req), 1);
      #2 rst = 1;
      #1;
      chk("s3_rd_req", int'(rd_req), 0);
      chk("s3_busy", int'(busy), 0);
      chk("s3_rd_addr", int'(rd_addr), 0);
      chk("s3_underflow", int'(underflow), 0);
      chk("s3_pixel", int'(pixel), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      run_line('{8'd31, 1'b0, 32, 320, 1'b1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
